cluster_load_ctrl: RTL and testbench

Load-and-configure sequencer for `PE_cluster`. It scans multicast IDs into the cluster, streams weights and activations from local buffers with their multicast tags, and pulses `start_compute_i`. It then waits for `flag_done` before reporting completion. It replaces the hand-driven loading sequence used in cluster bring-up and sits between the global buffers and one `PE_cluster` instance.

---
 rtl/cluster_load_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_cluster_load_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_load_ctrl.sv
// Load-and-configure sequencer for one PE_cluster: scans multicast IDs, streams tagged
// weight/activation beats from local buffers, pulses start_compute and waits for flag_done.
module cluster_load_ctrl #(
  parameter int idSize   = 8,
  parameter int dataSize = 8,
  parameter int addrSize = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [7:0]            num_act_ids_i,
  input  logic [7:0]            num_weight_ids_i,
  input  logic [7:0]            num_w_tags_i,
  input  logic [7:0]            num_a_tags_i,
  input  logic [7:0]            ctrl_wcount_i,
  input  logic [7:0]            ctrl_acount_i,
  output logic [addrSize-1:0]   cfg_rd_addr_o,
  input  logic [2*idSize-1:0]   cfg_rd_data_i,
  output logic [addrSize-1:0]   w_rd_addr_o,
  input  logic [dataSize-1:0]   w_rd_data_i,
  output logic [addrSize-1:0]   a_rd_addr_o,
  input  logic [dataSize-1:0]   a_rd_data_i,
  output logic [idSize-1:0]     act_id_scan_o,
  output logic [idSize-1:0]     weight_id_scan_o,
  output logic                  act_id_wren_o,
  output logic                  weight_id_wren_o,
  output logic [idSize-1:0]     weight_mcn_tag_target_x_o,
  output logic [idSize-1:0]     weight_mcn_tag_target_y_o,
  output logic [idSize-1:0]     act_mcn_tag_target_x_o,
  output logic [idSize-1:0]     act_mcn_tag_target_y_o,
  output logic [dataSize-1:0]   w_data_o,
  output logic [dataSize-1:0]   a_data_o,
  output logic [7:0]            ctrl_wcount_o,
  output logic [7:0]            ctrl_acount_o,
  output logic                  cluster_enable_o,
  output logic                  start_compute_o,
  input  logic                  flag_done_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [3:0]            state_o
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_SCAN_AID = 4'd1;
  localparam logic [3:0] S_AID_WREN = 4'd2;
  localparam logic [3:0] S_SCAN_WID = 4'd3;
  localparam logic [3:0] S_WID_WREN = 4'd4;
  localparam logic [3:0] S_LOAD_W   = 4'd5;
  localparam logic [3:0] S_LOAD_A   = 4'd6;
  localparam logic [3:0] S_GAP      = 4'd7;
  localparam logic [3:0] S_START    = 4'd8;
  localparam logic [3:0] S_COMPUTE  = 4'd9;
  localparam logic [3:0] S_DONE     = 4'd10;

  logic [3:0]          state, next_state;
  logic [7:0]          na_q, nw_q, tw_q, ta_q, wc_q, ac_q;
  logic [7:0]          cnt, beat, beat_last;
  logic [addrSize-1:0] dptr;
  logic [7:0]          na_s, nw_s, tw_s, ta_s, wc_s, ac_s;
  logic                go_aid, go_wid, go_w, go_a;
  logic [3:0]          entry_st, after_aid, after_wid, after_w;

  // Start handshake: start_i is only looked at in IDLE; busy_o is the "not ready" indication.
  // Skip decisions in IDLE use the live config inputs because they are captured on that edge.
  always_comb begin
    na_s = (state == S_IDLE) ? num_act_ids_i    : na_q;
    nw_s = (state == S_IDLE) ? num_weight_ids_i : nw_q;
    tw_s = (state == S_IDLE) ? num_w_tags_i     : tw_q;
    ta_s = (state == S_IDLE) ? num_a_tags_i     : ta_q;
    wc_s = (state == S_IDLE) ? ctrl_wcount_i    : wc_q;
    ac_s = (state == S_IDLE) ? ctrl_acount_i    : ac_q;
    go_aid    = |na_s;
    go_wid    = |nw_s;
    go_w      = |tw_s && |wc_s;
    go_a      = |ta_s && |ac_s;
    after_w   = go_a   ? S_LOAD_A   : S_GAP;
    after_wid = go_w   ? S_LOAD_W   : after_w;
    after_aid = go_wid ? S_SCAN_WID : after_wid;
    entry_st  = go_aid ? S_SCAN_AID : after_aid;
    beat_last = (state == S_LOAD_W) ? wc_q - 8'd1 : ac_q - 8'd1;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (start_i) next_state = entry_st;
      S_SCAN_AID: if (cnt == na_q - 8'd1) next_state = S_AID_WREN;
      S_AID_WREN: next_state = after_aid;
      S_SCAN_WID: if (cnt == nw_q - 8'd1) next_state = S_WID_WREN;
      S_WID_WREN: next_state = after_wid;
      S_LOAD_W:   if (beat == beat_last && cnt == tw_q - 8'd1) next_state = after_w;
      S_LOAD_A:   if (beat == beat_last && cnt == ta_q - 8'd1) next_state = S_GAP;
      S_GAP:      next_state = S_START;
      S_START:    next_state = S_COMPUTE;
      S_COMPUTE:  if (flag_done_i) next_state = S_DONE;
      S_DONE:     next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
    if (abort_i) next_state = S_IDLE;
  end

  always_comb begin
    cfg_rd_addr_o = '0;
    case (state)
      S_SCAN_AID: cfg_rd_addr_o = addrSize'(cnt);
      S_SCAN_WID: cfg_rd_addr_o = addrSize'(na_q) + addrSize'(cnt);
      S_LOAD_W:   cfg_rd_addr_o = addrSize'(na_q) + addrSize'(nw_q) + addrSize'(cnt);
      S_LOAD_A:   cfg_rd_addr_o = addrSize'(na_q) + addrSize'(nw_q) + addrSize'(tw_q) + addrSize'(cnt);
      default:    cfg_rd_addr_o = '0;
    endcase
  end

  assign w_rd_addr_o   = dptr;
  assign a_rd_addr_o   = dptr;
  assign ctrl_wcount_o = wc_q;
  assign ctrl_acount_o = ac_q;
  assign state_o       = state;

  // cnt is the ID index in scan phases and the tag-group index in load phases.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
      cnt   <= '0;
      beat  <= '0;
      dptr  <= '0;
      na_q  <= '0;
      nw_q  <= '0;
      tw_q  <= '0;
      ta_q  <= '0;
      wc_q  <= '0;
      ac_q  <= '0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && start_i && !abort_i) begin
        na_q <= num_act_ids_i;
        nw_q <= num_weight_ids_i;
        tw_q <= num_w_tags_i;
        ta_q <= num_a_tags_i;
        wc_q <= ctrl_wcount_i;
        ac_q <= ctrl_acount_i;
      end
      if (next_state != state) begin
        cnt  <= '0;
        beat <= '0;
        dptr <= '0;
      end else begin
        case (state)
          S_SCAN_AID, S_SCAN_WID: cnt <= cnt + 8'd1;
          S_LOAD_W, S_LOAD_A: begin
            dptr <= dptr + addrSize'(1);
            if (beat == beat_last) begin
              beat <= '0;
              cnt  <= cnt + 8'd1;
            end else begin
              beat <= beat + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Abort clears every cluster-facing output except the captured counts.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst || abort_i) begin
      if (!nrst || abort_i) begin
        act_id_scan_o             <= '1;
        weight_id_scan_o          <= '1;
        act_id_wren_o             <= 1'b0;
        weight_id_wren_o          <= 1'b0;
        weight_mcn_tag_target_x_o <= '1;
        weight_mcn_tag_target_y_o <= '1;
        act_mcn_tag_target_x_o    <= '1;
        act_mcn_tag_target_y_o    <= '1;
        w_data_o                  <= '0;
        a_data_o                  <= '0;
        start_compute_o           <= 1'b0;
        done_o                    <= 1'b0;
        busy_o                    <= 1'b0;
        cluster_enable_o          <= 1'b0;
      end
    end else begin
      act_id_wren_o    <= (state == S_AID_WREN);
      weight_id_wren_o <= (state == S_WID_WREN);
      if (state == S_SCAN_AID) act_id_scan_o <= cfg_rd_data_i[idSize-1:0];
      if (state == S_SCAN_WID) weight_id_scan_o <= cfg_rd_data_i[idSize-1:0];
      if (state == S_LOAD_W) begin
        {weight_mcn_tag_target_y_o, weight_mcn_tag_target_x_o} <= cfg_rd_data_i;
        w_data_o <= w_rd_data_i;
      end else begin
        weight_mcn_tag_target_y_o <= '1;
        weight_mcn_tag_target_x_o <= '1;
      end
      if (state == S_LOAD_A) begin
        {act_mcn_tag_target_y_o, act_mcn_tag_target_x_o} <= cfg_rd_data_i;
        a_data_o <= a_rd_data_i;
      end else begin
        act_mcn_tag_target_y_o <= '1;
        act_mcn_tag_target_x_o <= '1;
      end
      start_compute_o  <= (state == S_START);
      done_o           <= (state == S_DONE);
      busy_o           <= (next_state != S_IDLE);
      cluster_enable_o <= (next_state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_cluster_load_ctrl.sv
// Randomized bench for cluster_load_ctrl: a job-level model predicts timestamped output
// events into per-kind queues; a negedge monitor pops and compares them as the DUT emits.
module tb_cluster_load_ctrl;

  logic        clk = 1'b0;
  logic        nrst, start_i, abort_i, flag_done_i;
  logic [7:0]  num_act_ids_i, num_weight_ids_i, num_w_tags_i, num_a_tags_i;
  logic [7:0]  ctrl_wcount_i, ctrl_acount_i;
  logic [15:0] cfg_rd_addr_o, w_rd_addr_o, a_rd_addr_o;
  logic [15:0] cfg_rd_data_i;
  logic [7:0]  w_rd_data_i, a_rd_data_i;
  logic [7:0]  act_id_scan_o, weight_id_scan_o;
  logic        act_id_wren_o, weight_id_wren_o;
  logic [7:0]  wtx, wty, atx, aty, w_data_o, a_data_o;
  logic [7:0]  ctrl_wcount_o, ctrl_acount_o;
  logic        cluster_enable_o, start_compute_o, busy_o, done_o;
  logic [3:0]  state_o;

  logic [15:0] cfg_mem [0:1023];
  logic [7:0]  w_mem   [0:1023];
  logic [7:0]  a_mem   [0:1023];

  assign cfg_rd_data_i = cfg_mem[cfg_rd_addr_o[9:0]];
  assign w_rd_data_i   = w_mem[w_rd_addr_o[9:0]];
  assign a_rd_data_i   = a_mem[a_rd_addr_o[9:0]];

  cluster_load_ctrl #(.idSize(8), .dataSize(8), .addrSize(16)) dut (
    .clk(clk), .nrst(nrst), .start_i(start_i), .abort_i(abort_i),
    .num_act_ids_i(num_act_ids_i), .num_weight_ids_i(num_weight_ids_i),
    .num_w_tags_i(num_w_tags_i), .num_a_tags_i(num_a_tags_i),
    .ctrl_wcount_i(ctrl_wcount_i), .ctrl_acount_i(ctrl_acount_i),
    .cfg_rd_addr_o(cfg_rd_addr_o), .cfg_rd_data_i(cfg_rd_data_i),
    .w_rd_addr_o(w_rd_addr_o), .w_rd_data_i(w_rd_data_i),
    .a_rd_addr_o(a_rd_addr_o), .a_rd_data_i(a_rd_data_i),
    .act_id_scan_o(act_id_scan_o), .weight_id_scan_o(weight_id_scan_o),
    .act_id_wren_o(act_id_wren_o), .weight_id_wren_o(weight_id_wren_o),
    .weight_mcn_tag_target_x_o(wtx), .weight_mcn_tag_target_y_o(wty),
    .act_mcn_tag_target_x_o(atx), .act_mcn_tag_target_y_o(aty),
    .w_data_o(w_data_o), .a_data_o(a_data_o),
    .ctrl_wcount_o(ctrl_wcount_o), .ctrl_acount_o(ctrl_acount_o),
    .cluster_enable_o(cluster_enable_o), .start_compute_o(start_compute_o),
    .flag_done_i(flag_done_i), .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    int          cyc;
    logic [23:0] val;
  } ev_t;

  // kinds: 0 act id, 1 act wren, 2 wt id, 3 wt wren, 4 w beat, 5 a beat, 6 start, 7 done
  ev_t evq [8][$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  mon_on = 1'b0;
  int  j_na, j_nw, j_tw, j_wc, j_ta, j_ac;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic handle(input int k, input string name, input logic present,
                        input bit timed_only, input logic [23:0] act);
    ev_t e;
    while (evq[k].size() > 0 && evq[k][0].cyc < cyc) begin
      e = evq[k].pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s missing at cyc=%0d actual=none required=%h", name, e.cyc, e.val);
    end
    if (evq[k].size() > 0 && evq[k][0].cyc == cyc) begin
      e = evq[k].pop_front();
      check(name, {7'd0, present, act}, {8'h01, e.val});
    end else if (present && !timed_only) begin
      check({name, "_unexpected"}, {7'd0, present, act}, 32'h0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      handle(0, "act_id",  1'b1, 1'b1, {16'd0, act_id_scan_o});
      handle(1, "act_wren", act_id_wren_o, 1'b0, {16'd0, act_id_scan_o});
      handle(2, "wt_id",   1'b1, 1'b1, {16'd0, weight_id_scan_o});
      handle(3, "wt_wren", weight_id_wren_o, 1'b0, {16'd0, weight_id_scan_o});
      handle(4, "w_beat", (wtx != 8'hFF || wty != 8'hFF), 1'b0, {wty, wtx, w_data_o});
      handle(5, "a_beat", (atx != 8'hFF || aty != 8'hFF), 1'b0, {aty, atx, a_data_o});
      handle(6, "start_compute", start_compute_o, 1'b0, 24'd0);
      handle(7, "done", done_o, 1'b0, 24'd0);
    end
  end

  // ---------------- reference model ----------------
  task automatic put(input int k, input int c, input logic [23:0] v, input int lim);
    ev_t e;
    e.cyc = c;
    e.val = v;
    if (c <= lim) evq[k].push_back(e);
  endtask

  // Walks the job phase by phase; first output appears two cycles after start is sampled.
  task automatic push_job(input int s0, input int lim, output int st);
    int c;
    c = s0 + 2;
    if (j_na > 0) begin
      for (int i = 0; i < j_na; i++) begin put(0, c, {16'd0, cfg_mem[i][7:0]}, lim); c++; end
      put(1, c, {16'd0, cfg_mem[j_na-1][7:0]}, lim); c++;
    end
    if (j_nw > 0) begin
      for (int i = 0; i < j_nw; i++) begin put(2, c, {16'd0, cfg_mem[j_na+i][7:0]}, lim); c++; end
      put(3, c, {16'd0, cfg_mem[j_na+j_nw-1][7:0]}, lim); c++;
    end
    if (j_tw > 0 && j_wc > 0)
      for (int g = 0; g < j_tw; g++)
        for (int b = 0; b < j_wc; b++) begin
          put(4, c, {cfg_mem[j_na+j_nw+g], w_mem[g*j_wc+b]}, lim); c++;
        end
    if (j_ta > 0 && j_ac > 0)
      for (int g = 0; g < j_ta; g++)
        for (int b = 0; b < j_ac; b++) begin
          put(5, c, {cfg_mem[j_na+j_nw+j_tw+g], a_mem[g*j_ac+b]}, lim); c++;
        end
    c++;
    put(6, c, 24'd0, lim);
    st = c;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) begin
      cfg_mem[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 254))};
      w_mem[i]   = 8'($urandom_range(0, 255));
      a_mem[i]   = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic scramble_cfg();
    num_act_ids_i    = 8'($urandom_range(0, 255));
    num_weight_ids_i = 8'($urandom_range(0, 255));
    num_w_tags_i     = 8'($urandom_range(0, 255));
    num_a_tags_i     = 8'($urandom_range(0, 255));
    ctrl_wcount_i    = 8'($urandom_range(0, 255));
    ctrl_acount_i    = 8'($urandom_range(0, 255));
  endtask

  task automatic start_job(input int lim_off, output int s0, output int st);
    num_act_ids_i    = 8'(j_na);
    num_weight_ids_i = 8'(j_nw);
    num_w_tags_i     = 8'(j_tw);
    num_a_tags_i     = 8'(j_ta);
    ctrl_wcount_i    = 8'(j_wc);
    ctrl_acount_i    = 8'(j_ac);
    start_i = 1'b1;
    s0 = cyc;
    push_job(s0, s0 + lim_off, st);
    tick();
    start_i = 1'b0;
    scramble_cfg();
    check("busy_after_start", {30'd0, busy_o, cluster_enable_o}, 32'd3);
  endtask

  task automatic complete_job(input int st, input int delay);
    int  f;
    ev_t e;
    wait_until(st + delay);
    flag_done_i = 1'b1;
    f = cyc;
    e.cyc = f + 2;
    e.val = 24'd0;
    evq[7].push_back(e);
    tick();
    flag_done_i = 1'b0;
    wait_until(f + 2);
    check("busy_after_done", {30'd0, busy_o, cluster_enable_o}, 32'd0);
    wait_until(f + 3);
    check("tags_after_done", {wtx, wty, atx, aty}, 32'hFFFF_FFFF);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_tags"}, {wtx, wty, atx, aty}, 32'hFFFF_FFFF);
    check({tag, "_ids"}, {16'd0, act_id_scan_o, weight_id_scan_o}, 32'h0000_FFFF);
    check({tag, "_data"}, {16'd0, w_data_o, a_data_o}, 32'd0);
    check({tag, "_ctl"}, {26'd0, act_id_wren_o, weight_id_wren_o, start_compute_o,
                          done_o, busy_o, cluster_enable_o}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s0, st, big;
    big = 1 << 20;
    nrst = 1'b0; start_i = 1'b0; abort_i = 1'b0; flag_done_i = 1'b0;
    scramble_cfg();
    fill_mem();
    tick(); tick();
    check_cleared("reset");
    check("reset_counts", {16'd0, ctrl_wcount_o, ctrl_acount_o}, 32'd0);
    nrst = 1'b1;
    tick();
    mon_on = 1'b1;

    // Nominal job, with a stray flag_done during scan and a start pulse during LOAD_W.
    j_na = 3; j_nw = 3; j_tw = 3; j_wc = 3; j_ta = 5; j_ac = 5;
    fill_mem();
    start_job(big, s0, st);
    check("nominal_start_cycle", st - s0, 45);
    wait_until(s0 + 3);
    flag_done_i = 1'b1;
    tick();
    flag_done_i = 1'b0;
    wait_until(s0 + 13);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    complete_job(st, 10);
    check("counts_not_recaptured", {16'd0, ctrl_wcount_o, ctrl_acount_o}, {16'd0, 8'd3, 8'd5});

    // Back-to-back: same job started the cycle after done_o.
    start_job(big, s0, st);
    complete_job(st, 10);

    // Skipped phases: no act IDs, no weight beats.
    j_na = 0; j_nw = 3; j_tw = 0; j_wc = 4; j_ta = 2; j_ac = 3;
    fill_mem();
    start_job(big, s0, st);
    complete_job(st, 4);

    // Weight tags present but wc=0: act tags still sit after the Tw weight-tag slots.
    j_na = 2; j_nw = 1; j_tw = 2; j_wc = 0; j_ta = 3; j_ac = 2;
    fill_mem();
    start_job(big, s0, st);
    complete_job(st, 0);

    for (int r = 0; r < 6; r++) begin
      j_na = $urandom_range(0, 4); j_nw = $urandom_range(0, 4);
      j_tw = $urandom_range(0, 4); j_wc = $urandom_range(0, 4);
      j_ta = $urandom_range(0, 4); j_ac = $urandom_range(0, 4);
      fill_mem();
      start_job(big, s0, st);
      complete_job(st, $urandom_range(0, 6));
      repeat ($urandom_range(0, 3)) tick();
    end

    // Abort at LOAD_A beat 7.
    j_na = 3; j_nw = 3; j_tw = 3; j_wc = 3; j_ta = 5; j_ac = 5;
    fill_mem();
    start_job(25, s0, st);
    wait_until(s0 + 25);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check_cleared("abort");
    check("abort_counts_hold", {16'd0, ctrl_wcount_o, ctrl_acount_o}, {16'd0, 8'd3, 8'd5});
    repeat (30) tick();

    // Abort and flag_done together in COMPUTE: abort wins, no done pulse.
    start_job(big, s0, st);
    wait_until(st + 2);
    abort_i = 1'b1;
    flag_done_i = 1'b1;
    tick();
    abort_i = 1'b0;
    flag_done_i = 1'b0;
    check_cleared("abort_vs_done");
    repeat (10) tick();

    // Asynchronous reset at the same point in LOAD_A.
    start_job(24, s0, st);
    wait_until(s0 + 25);
    #1;
    nrst = 1'b0;
    #1;
    check_cleared("nrst");
    check("nrst_counts", {16'd0, ctrl_wcount_o, ctrl_acount_o}, 32'd0);
    tick(); tick();
    nrst = 1'b1;
    tick();

    // Recovery job after reset.
    j_na = 1; j_nw = 2; j_tw = 1; j_wc = 2; j_ta = 2; j_ac = 1;
    fill_mem();
    start_job(big, s0, st);
    complete_job(st, 3);
    repeat (5) tick();

    for (int k = 0; k < 8; k++)
      while (evq[k].size() > 0) begin
        ev_t e;
        e = evq[k].pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL leftover kind=%0d actual=none required=%h at cyc=%0d", k, e.val, e.cyc);
      end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog actual=timeout required=finish cyc=%0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
